gb_pe_feeder: RTL and testbench

//  Transmit side of the PE array's input-FIFO interface. Reads filter and ifmap words from the global buffer.

---
 rtl/gb_pe_feeder_pkg.sv | 17 +
 rtl/gb_pe_feeder_if.sv | 24 ++
 rtl/gb_pe_feeder_onehot_dec.sv | 33 +++
 rtl/gb_pe_feeder.sv | 193 +++++++++++++++++++
 tb/tb_gb_pe_feeder.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/gb_pe_feeder_pkg.sv
// Shared encodings for the global-buffer to PE-FIFO feeder.
// The FSM states and the filter/ifmap phase select live here.
package gb_pe_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        PH_FILTER = 1'b0,
        PH_IFMAP  = 1'b1
    } phase_t;

endpackage

// File: rtl/gb_pe_feeder_if.sv
// Bus between the feeder, the global buffer read port and the per-PE FIFO banks.
interface gb_pe_feeder_if #(
    parameter int N          = 3,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] gb_raddr;
    logic [DATA_WIDTH-1:0] gb_dout;
    logic [N-1:0]          ready_filter;
    logic [N-1:0]          ready_ifmap;
    logic [DATA_WIDTH-1:0] fifo_din;
    logic [N-1:0]          wen_filter;
    logic [N-1:0]          wen_ifmap;

    modport master (
        output gb_raddr, fifo_din, wen_filter, wen_ifmap,
        input  gb_dout, ready_filter, ready_ifmap
    );

    modport slave (
        input  gb_raddr, fifo_din, wen_filter, wen_ifmap,
        output gb_dout, ready_filter, ready_ifmap
    );
endinterface

// File: rtl/gb_pe_feeder_onehot_dec.sv
// PE index to one-hot write enable, steered onto the filter or ifmap bank.
// Out-of-range indices decode to all-zero so no stray write can occur.
module onehot_dec
    import gb_pe_feeder_pkg::*;
#(
    parameter int N       = 3,
    parameter int N_WIDTH = 2
) (
    input  logic [N_WIDTH-1:0] idx,
    input  logic               en,
    input  phase_t             phase,
    output logic [N-1:0]       oh_filter,
    output logic [N-1:0]       oh_ifmap
);

    // Decode the index into exactly one bank's enable vector
    always_comb begin
        oh_filter = '0;
        oh_ifmap  = '0;
        for (int i = 0; i < N; i++) begin
            if (en && (idx == N_WIDTH'(i))) begin
                if (phase == PH_IFMAP) begin
                    oh_ifmap[i] = 1'b1;
                end else begin
                    oh_filter[i] = 1'b1;
                end
            end else begin
                oh_filter[i] = oh_filter[i];
            end
        end
    end

endmodule

// File: rtl/gb_pe_feeder.sv
// Streams filter then ifmap words for PE 0..N-1 from the global buffer into the
// per-PE FIFOs, alternating read-issue and write cycles (1 word per 2 cycles).
module gb_pe_feeder
    import gb_pe_feeder_pkg::*;
#(
    parameter int N          = 3,
    parameter int N_WIDTH    = 2,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] filter_base,
    input  logic [ADDR_WIDTH-1:0] ifmap_base,
    input  logic [LEN_WIDTH-1:0]  filter_len,
    input  logic [LEN_WIDTH-1:0]  ifmap_len,
    gb_pe_feeder_if.master        bus,
    output logic                  busy,
    output logic                  done
);

    state_t                state_r, next_state_s;
    phase_t                phase_r;
    logic [N_WIDTH-1:0]    pe_r;
    logic [LEN_WIDTH-1:0]  cnt_r;
    logic [LEN_WIDTH-1:0]  flen_r, ilen_r;
    logic [ADDR_WIDTH-1:0] cur_addr_r;
    // f_acc_r / i_acc_r hold the base address of the current (or next) PE's block
    logic [ADDR_WIDTH-1:0] f_acc_r, i_acc_r;
    logic [ADDR_WIDTH-1:0] addr_inc_s;
    logic [LEN_WIDTH-1:0]  cur_len_s;
    logic                  last_word_s, last_pe_s, ready_sel_s, finish_s;
    logic [N-1:0]          oh_filter_s, oh_ifmap_s;
    logic [N-1:0]          wen_filter_r, wen_ifmap_r;
    logic                  busy_r, done_r;

    assign addr_inc_s  = cur_addr_r + ADDR_WIDTH'(1);
    assign cur_len_s   = (phase_r == PH_IFMAP) ? ilen_r : flen_r;
    assign last_word_s = (cnt_r == (cur_len_s - LEN_WIDTH'(1)));
    assign last_pe_s   = (pe_r == N_WIDTH'(N - 1));
    // Transfer ends after the last PE's ifmap phase, or its filter phase when ifmap is empty
    assign finish_s    = last_word_s && last_pe_s &&
                         ((phase_r == PH_IFMAP) || (ilen_r == LEN_WIDTH'(0)));

    // Pick the ready bit of the FIFO targeted by the current PE and phase
    always_comb begin
        ready_sel_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (pe_r == N_WIDTH'(i)) begin
                ready_sel_s = (phase_r == PH_IFMAP) ? bus.ready_ifmap[i] : bus.ready_filter[i];
            end else begin
                ready_sel_s = ready_sel_s;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state selection
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ((filter_len == LEN_WIDTH'(0)) && (ifmap_len == LEN_WIDTH'(0)))
                                   ? ST_DONE : ST_ISSUE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (ready_sel_s) begin
                    next_state_s = ST_WRITE;
                end else begin
                    next_state_s = ST_ISSUE;
                end
            end
            ST_WRITE: begin
                if (finish_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_ISSUE;
                end
            end
            ST_DONE:  next_state_s = ST_IDLE;
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // Counters and address accumulators; empty phases are skipped by look-ahead
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_r    <= PH_FILTER;
            pe_r       <= '0;
            cnt_r      <= '0;
            flen_r     <= '0;
            ilen_r     <= '0;
            cur_addr_r <= '0;
            f_acc_r    <= '0;
            i_acc_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        flen_r  <= filter_len;
                        ilen_r  <= ifmap_len;
                        f_acc_r <= filter_base;
                        i_acc_r <= ifmap_base;
                        pe_r    <= '0;
                        cnt_r   <= '0;
                        if (filter_len != LEN_WIDTH'(0)) begin
                            phase_r    <= PH_FILTER;
                            cur_addr_r <= filter_base;
                        end else begin
                            phase_r    <= PH_IFMAP;
                            cur_addr_r <= ifmap_base;
                        end
                    end
                end
                ST_WRITE: begin
                    if (!last_word_s) begin
                        cnt_r      <= cnt_r + LEN_WIDTH'(1);
                        cur_addr_r <= addr_inc_s;
                    end else begin
                        cnt_r <= '0;
                        if (phase_r == PH_FILTER) begin
                            f_acc_r <= addr_inc_s;
                            if (ilen_r != LEN_WIDTH'(0)) begin
                                phase_r    <= PH_IFMAP;
                                cur_addr_r <= i_acc_r;
                            end else begin
                                pe_r       <= pe_r + N_WIDTH'(1);
                                cur_addr_r <= addr_inc_s;
                            end
                        end else begin
                            i_acc_r <= addr_inc_s;
                            pe_r    <= pe_r + N_WIDTH'(1);
                            if (flen_r != LEN_WIDTH'(0)) begin
                                phase_r    <= PH_FILTER;
                                cur_addr_r <= f_acc_r;
                            end else begin
                                cur_addr_r <= addr_inc_s;
                            end
                        end
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    onehot_dec #(.N(N), .N_WIDTH(N_WIDTH)) u_dec (
        .idx       (pe_r),
        .en        (next_state_s == ST_WRITE),
        .phase     (phase_r),
        .oh_filter (oh_filter_s),
        .oh_ifmap  (oh_ifmap_s)
    );

    // Output registers, loaded from the state about to be entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_filter_r <= '0;
            wen_ifmap_r  <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            wen_filter_r <= oh_filter_s;
            wen_ifmap_r  <= oh_ifmap_s;
            busy_r       <= (next_state_s != ST_IDLE);
            done_r       <= (next_state_s == ST_DONE);
        end
    end

    assign bus.gb_raddr   = cur_addr_r;
    assign bus.fifo_din   = bus.gb_dout;
    assign bus.wen_filter = wen_filter_r;
    assign bus.wen_ifmap  = wen_ifmap_r;
    assign busy           = busy_r;
    assign done           = done_r;

endmodule

// File: tb/tb_gb_pe_feeder.sv
// Directed bench for gb_pe_feeder: write order, timing, backpressure, empty phases,
// address wrap, mid-transfer reset and start-while-busy.
module tb_gb_pe_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] filter_base, ifmap_base, filter_len, ifmap_len;
    logic       busy, done;

    gb_pe_feeder_if #(.N(3), .DATA_WIDTH(16), .ADDR_WIDTH(8)) bus_if ();

    gb_pe_feeder #(.N(3), .N_WIDTH(2), .DATA_WIDTH(16), .ADDR_WIDTH(8), .LEN_WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .filter_base (filter_base),
        .ifmap_base  (ifmap_base),
        .filter_len  (filter_len),
        .ifmap_len   (ifmap_len),
        .bus         (bus_if.master),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int t0  = 0;
    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int done_rel = -1;
    int onehot_bad = 0;
    logic mon_en = 1'b0;
    int         wr_cyc[$];
    logic [5:0] wr_sel[$];
    logic [15:0] wr_data[$];
    logic [7:0] exp_addr[$];
    logic [5:0] exp_sel[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Global buffer model: registered read, word tagged with its own address
    always @(posedge clk) bus_if.gb_dout <= {8'hA5, bus_if.gb_raddr};

    // Write / done monitor
    always @(negedge clk) begin
        if (mon_en) begin
            if ((bus_if.wen_filter | bus_if.wen_ifmap) != 3'b000) begin
                if ($countones({bus_if.wen_ifmap, bus_if.wen_filter}) != 1) onehot_bad++;
                wr_cyc.push_back(cyc - t0);
                wr_sel.push_back({bus_if.wen_ifmap, bus_if.wen_filter});
                wr_data.push_back(bus_if.fifo_din);
            end
            if (done) begin
                done_cnt++;
                done_rel = cyc - t0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_rel(input int k);
        while ((cyc - t0) < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic build_exp(input int fb, input int ib, input int fl, input int il);
        exp_addr.delete();
        exp_sel.delete();
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < fl; k++) begin
                exp_addr.push_back(8'((fb + p * fl + k) & 255));
                exp_sel.push_back(6'(1 << p));
            end
            for (int k = 0; k < il; k++) begin
                exp_addr.push_back(8'((ib + p * il + k) & 255));
                exp_sel.push_back(6'(1 << (p + 3)));
            end
        end
    endtask

    task automatic launch(input int fb, input int ib, input int fl, input int il);
        @(posedge clk);
        #1;
        filter_base = 8'(fb);
        ifmap_base  = 8'(ib);
        filter_len  = 8'(fl);
        ifmap_len   = 8'(il);
        start       = 1'b1;
        wr_cyc.delete();
        wr_sel.delete();
        wr_data.delete();
        done_cnt   = 0;
        done_rel   = -1;
        onehot_bad = 0;
        t0         = cyc;
        mon_en     = 1'b1;
        build_exp(fb, ib, fl, il);
        chk("busy_at_start", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("done_pulses", done_cnt, 32'd1);
    endtask

    task automatic check_run(input string tag, input int stall_idx, input int stall_len);
        int n;
        int extra;
        n = exp_addr.size();
        chk({tag, "_nwrites"}, wr_cyc.size(), n);
        chk({tag, "_onehot"}, onehot_bad, 32'd0);
        for (int i = 0; i < n && i < wr_cyc.size(); i++) begin
            extra = (i >= stall_idx) ? stall_len : 0;
            chk($sformatf("%s_cyc%0d", tag, i), wr_cyc[i], 2 + 2 * i + extra);
            chk($sformatf("%s_sel%0d", tag, i), {26'd0, wr_sel[i]}, {26'd0, exp_sel[i]});
            chk($sformatf("%s_data%0d", tag, i), {16'd0, wr_data[i]}, {16'd0, 8'hA5, exp_addr[i]});
        end
        chk({tag, "_done_cyc"}, done_rel, 2 * n + 1 + stall_len);
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        filter_base = 8'd0;
        ifmap_base = 8'd0;
        filter_len = 8'd0;
        ifmap_len = 8'd0;
        bus_if.ready_filter = 3'b111;
        bus_if.ready_ifmap  = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_raddr", {24'd0, bus_if.gb_raddr}, 32'd0);
        chk("rst_wen", {26'd0, bus_if.wen_ifmap, bus_if.wen_filter}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;

        // Basic: 18 writes at even cycles 2..36, done at 37
        launch(0, 16, 2, 4);
        wait_done(100);
        check_run("basic", 1000, 0);

        // Backpressure on PE1 ifmap while issuing word index 9 (address 21)
        launch(0, 16, 2, 4);
        wait_rel(19);
        bus_if.ready_ifmap = 3'b101;
        wait_rel(24);
        chk("stall_raddr", {24'd0, bus_if.gb_raddr}, 32'd21);
        chk("stall_wen", {26'd0, bus_if.wen_ifmap, bus_if.wen_filter}, 32'd0);
        wait_rel(29);
        bus_if.ready_ifmap = 3'b111;
        wait_done(100);
        check_run("stall", 9, 10);

        // Empty filter phase: 9 ifmap writes, done at 19
        launch(40, 60, 0, 3);
        wait_done(100);
        check_run("zero_f", 1000, 0);

        // Both phases empty: no writes, done right after start
        launch(5, 6, 0, 0);
        wait_done(20);
        chk("zero_both_nwrites", wr_cyc.size(), 32'd0);
        chk("zero_both_done_cyc", {31'd0, (done_rel >= 1 && done_rel <= 2)}, 32'd1);

        // Ifmap addresses wrap: 254,255 / 0,1 / 2,3
        launch(100, 254, 1, 2);
        wait_done(100);
        check_run("wrap", 1000, 0);

        // Reset during PE1 filter phase
        launch(0, 16, 2, 4);
        wait_rel(14);
        rst = 1'b1;
        #1;
        chk("midrst_raddr", {24'd0, bus_if.gb_raddr}, 32'd0);
        chk("midrst_wen", {26'd0, bus_if.wen_ifmap, bus_if.wen_filter}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_nwrites", wr_cyc.size(), 32'd6);
        chk("midrst_nodone", done_cnt, 32'd0);
        rst = 1'b0;
        launch(0, 16, 2, 4);
        wait_done(100);
        check_run("after_rst", 1000, 0);

        // Start while busy with different parameters is ignored
        launch(0, 16, 2, 4);
        wait_rel(5);
        filter_base = 8'd100;
        ifmap_base  = 8'd200;
        filter_len  = 8'd1;
        ifmap_len   = 8'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(100);
        check_run("restart", 1000, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("restart_idle", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
